// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit type codes, field positions, output port codes, rx framing states.
package noc_pkg;

  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned PORT_W    = 3;
  localparam int unsigned TYPE_MSB  = 31;
  localparam int unsigned TYPE_LSB  = 30;
  localparam int unsigned DST_X_MSB = 29;
  localparam int unsigned DST_X_LSB = 28;
  localparam int unsigned DST_Y_MSB = 27;
  localparam int unsigned DST_Y_LSB = 26;

  typedef enum logic [1:0] {
    FT_BODY = 2'b00,
    FT_TAIL = 2'b01,
    FT_IDLE = 2'b10,
    FT_HEAD = 2'b11
  } flit_type_e;

  typedef enum logic [PORT_W-1:0] {
    PORT_LOCAL = 3'd0,
    PORT_EAST  = 3'd1,
    PORT_WEST  = 3'd2,
    PORT_NORTH = 3'd3,
    PORT_SOUTH = 3'd4
  } port_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/xy_route.sv
// Combinational XY dimension-order route: resolve X first, then Y, else deliver locally.
module xy_route
  import noc_pkg::*;
#(
  parameter int unsigned MY_X = 0,
  parameter int unsigned MY_Y = 0
) (
  input  logic [1:0]        dst_x,
  input  logic [1:0]        dst_y,
  output logic [PORT_W-1:0] out_port
);

  always_comb begin
    out_port = PORT_LOCAL;
    if (dst_x > 2'(MY_X)) begin
      out_port = PORT_EAST;
    end else if (dst_x < 2'(MY_X)) begin
      out_port = PORT_WEST;
    end else if (dst_y > 2'(MY_Y)) begin
      out_port = PORT_NORTH;
    end else if (dst_y < 2'(MY_Y)) begin
      out_port = PORT_SOUTH;
    end
  end

endmodule

// File: rtl/flit_in_buffer.sv
// Router input buffer: head/body/tail framing check, FIFO storage and XY route of the packet at the head.
// Optional FLIT_BUF_STATS_EN adds pkt_cnt (TAIL pops, wrapping) and err_cnt (frame errors, saturating).
module flit_in_buffer
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_out_valid,
  input  logic              flit_out_ready,
  output logic [PORT_W-1:0] out_port,
  output logic [ADDR_W:0]   count,
  output logic              frame_err
`ifdef FLIT_BUF_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        err_cnt
`endif
);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [PORT_W-1:0] route_q;
  logic [PORT_W-1:0] head_route;
  logic              frame_err_q;
  rx_state_e         state_q, state_d;
  logic              push, pop, err_d, handshake;
  flit_type_e        in_type, head_type;

  assign flit_in_ready  = (count_q != (ADDR_W+1)'(DEPTH));
  assign flit_out_valid = (count_q != '0);
  assign flit_out       = flit_out_valid ? mem_q[rd_ptr_q] : '0;
  assign count          = count_q;
  assign frame_err      = frame_err_q;

  assign handshake = flit_in_valid && flit_in_ready;
  assign pop       = flit_out_valid && flit_out_ready;
  assign in_type   = flit_type_e'(flit_in[TYPE_MSB:TYPE_LSB]);
  assign head_type = flit_type_e'(flit_out[TYPE_MSB:TYPE_LSB]);

  // Rx framing FSM: decides whether a handshaked flit is stored, dropped as an error, or ignored.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    err_d   = 1'b0;
    if (handshake) begin
      case (in_type)
        FT_HEAD: begin
          if (state_q == S_IDLE) begin
            push    = 1'b1;
            state_d = S_PKT;
          end else begin
            err_d = 1'b1;
          end
        end
        FT_BODY: begin
          if (state_q == S_PKT) push = 1'b1;
          else                  err_d = 1'b1;
        end
        FT_TAIL: begin
          if (state_q == S_PKT) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
        FT_IDLE: begin
          push = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= flit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  xy_route #(
    .MY_X (MY_X),
    .MY_Y (MY_Y)
  ) u_xy_route (
    .dst_x    (flit_out[DST_X_MSB:DST_X_LSB]),
    .dst_y    (flit_out[DST_Y_MSB:DST_Y_LSB]),
    .out_port (head_route)
  );

  // The packet route is latched when its HEAD leaves so body/tail flits keep steering the crossbar.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_q <= '0;
    end else if (pop && head_type == FT_HEAD) begin
      route_q <= head_route;
    end
  end

  always_comb begin
    out_port = route_q;
    if (flit_out_valid && head_type == FT_HEAD) out_port = head_route;
  end

`ifdef FLIT_BUF_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pop && head_type == FT_TAIL) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_flit_in_buffer.sv
// Bench for flit_in_buffer at MY=(1,1): directed scenarios plus random traffic against a queue-based model.
module tb_flit_in_buffer;

  localparam int MYX = 1;
  localparam int MYY = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] flit_in;
  logic        flit_in_valid;
  logic        flit_in_ready;
  logic [31:0] flit_out;
  logic        flit_out_valid;
  logic        flit_out_ready;
  logic [2:0]  out_port;
  logic [2:0]  count;
  logic        frame_err;
`ifdef FLIT_BUF_STATS_EN
  logic [15:0] pkt_cnt;
  logic [7:0]  err_cnt;
`endif

  flit_in_buffer #(
    .DEPTH  (4),
    .ADDR_W (2),
    .MY_X   (MYX),
    .MY_Y   (MYY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_in_valid  (flit_in_valid),
    .flit_in_ready  (flit_in_ready),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .flit_out_ready (flit_out_ready),
    .out_port       (out_port),
    .count          (count),
    .frame_err      (frame_err)
`ifdef FLIT_BUF_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt),
    .err_cnt        (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: packet-level view of the buffer.
  logic [31:0] q[$];
  bit          in_pkt;
  logic [2:0]  route_m;
  bit          err_m;
  int unsigned pkt_m;
  int unsigned errc_m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] route_of(input logic [31:0] f);
    int dx, dy;
    dx = int'(f[29:28]);
    dy = int'(f[27:26]);
    if (dx > MYX) return 3'd1;
    if (dx < MYX) return 3'd2;
    if (dy > MYY) return 3'd3;
    if (dy < MYY) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [1:0] x, input logic [1:0] y,
                                     input logic [25:0] pl);
    return {t, x, y, pl};
  endfunction

  task automatic model_reset();
    q.delete();
    in_pkt  = 0;
    route_m = 3'd0;
    err_m   = 0;
    pkt_m   = 0;
    errc_m  = 0;
  endtask

  task automatic model_update(input logic v, input logic [31:0] f, input logic r);
    int   sz;
    bit   hs, pp, pu;
    logic [31:0] f0;
    sz = q.size();
    hs = v && (sz < 4);
    pp = r && (sz > 0);
    pu = 0;
    err_m = 0;
    if (hs) begin
      case (f[31:30])
        2'b11: if (!in_pkt) begin pu = 1; in_pkt = 1; end else err_m = 1;
        2'b00: if (in_pkt) pu = 1; else err_m = 1;
        2'b01: if (in_pkt) begin pu = 1; in_pkt = 0; end else err_m = 1;
        default: ;
      endcase
    end
    if (pp) begin
      f0 = q.pop_front();
      if (f0[31:30] == 2'b11) route_m = route_of(f0);
      if (f0[31:30] == 2'b01) pkt_m = (pkt_m + 1) % 65536;
    end
    if (pu) q.push_back(f);
    if (err_m && errc_m < 255) errc_m++;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] head;
    logic [2:0]  op;
    head = (q.size() > 0) ? q[0] : 32'd0;
    op   = (q.size() > 0 && head[31:30] == 2'b11) ? route_of(head) : route_m;
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".in_rdy"}, 32'(flit_in_ready), 32'(q.size() < 4));
    check({tag, ".out_vld"}, 32'(flit_out_valid), 32'(q.size() > 0));
    check({tag, ".flit_out"}, flit_out, head);
    check({tag, ".out_port"}, 32'(out_port), 32'(op));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(err_m));
`ifdef FLIT_BUF_STATS_EN
    check({tag, ".pkt_cnt"}, 32'(pkt_cnt), 32'(pkt_m));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(errc_m));
`endif
  endtask

  // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input logic v, input logic [31:0] f, input logic r, input string tag);
    flit_in_valid  = v;
    flit_in        = f;
    flit_out_ready = r;
    @(posedge clk);
    model_update(v, f, r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 6; i++) begin
      if (q.size() > 0) step(1'b0, 32'd0, 1'b1, tag);
    end
  endtask

  task automatic do_reset(input string tag);
    flit_in_valid  = 1'b0;
    flit_out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    logic [31:0] f;
    logic [1:0]  t;
    int          errs;
    rst = 1'b1;
    flit_in = 32'd0;
    flit_in_valid = 1'b0;
    flit_out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset.count_zero", 32'(count), 32'd0);
    check("reset.ready_one", 32'(flit_in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // East-bound packet streamed straight through.
    step(1'b1, 32'hE000_0000, 1'b1, "east.h");
    check("east.h.port", 32'(out_port), 32'd1);
    check("east.h.data", flit_out, 32'hE000_0000);
    step(1'b1, mk(2'b00, 2'd0, 2'd0, 26'h0ABCDE), 1'b1, "east.b");
    check("east.b.port", 32'(out_port), 32'd1);
    step(1'b1, mk(2'b01, 2'd0, 2'd0, 26'h012345), 1'b1, "east.t");
    check("east.t.port", 32'(out_port), 32'd1);
    step(1'b0, 32'd0, 1'b1, "east.pop");

    // Reset in the middle of a packet returns the framer to idle.
    step(1'b1, mk(2'b11, 2'd1, 2'd1, 26'h1), 1'b0, "mid.h");
    step(1'b1, mk(2'b00, 2'd0, 2'd0, 26'h2), 1'b0, "mid.b");
    @(negedge clk);
    do_reset("mid.rst");
    check("mid.rst.count", 32'(count), 32'd0);
    check("mid.rst.valid", 32'(flit_out_valid), 32'd0);
    step(1'b1, mk(2'b00, 2'd0, 2'd0, 26'h3), 1'b0, "mid.b2");
    check("mid.b2.err", 32'(frame_err), 32'd1);
    check("mid.b2.count", 32'(count), 32'd0);

    // Fill to capacity, then one pop reopens the input.
    step(1'b1, mk(2'b11, 2'd0, 2'd2, 26'h10), 1'b0, "fill.0");
    for (int i = 1; i < 4; i++) step(1'b1, mk(2'b00, 2'd0, 2'd0, 26'(16 + i)), 1'b0, "fill.n");
    check("fill.count", 32'(count), 32'd4);
    check("fill.ready", 32'(flit_in_ready), 32'd0);
    step(1'b1, mk(2'b00, 2'd0, 2'd0, 26'h1F), 1'b0, "fill.5th");
    check("fill.5th.count", 32'(count), 32'd4);
    step(1'b0, 32'd0, 1'b1, "fill.pop");
    check("fill.pop.ready", 32'(flit_in_ready), 32'd1);
    check("fill.pop.count", 32'(count), 32'd3);
    step(1'b1, mk(2'b01, 2'd0, 2'd0, 26'h20), 1'b1, "fill.tail");
    drain("fill.drain");

    // Framing errors.
    step(1'b1, mk(2'b00, 2'd0, 2'd0, 26'h30), 1'b0, "frm.body");
    check("frm.body.err", 32'(frame_err), 32'd1);
    check("frm.body.count", 32'(count), 32'd0);
    errs = 0;
    step(1'b1, mk(2'b11, 2'd2, 2'd2, 26'h31), 1'b0, "frm.h1");
    errs += int'(frame_err);
    step(1'b1, mk(2'b11, 2'd0, 2'd0, 26'h32), 1'b0, "frm.h2");
    errs += int'(frame_err);
    step(1'b1, mk(2'b01, 2'd0, 2'd0, 26'h33), 1'b0, "frm.t");
    errs += int'(frame_err);
    check("frm.stored", 32'(count), 32'd2);
    check("frm.pulses", 32'(errs), 32'd1);

    // Concurrent push and pop at occupancy two.
    step(1'b1, mk(2'b11, 2'd1, 2'd0, 26'h40), 1'b1, "cc.h");
    check("cc.h.count", 32'(count), 32'd2);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(2'b00, 2'd0, 2'd0, 26'(65 + i)), 1'b1, "cc.b");
      check($sformatf("cc.b%0d.count", i), 32'(count), 32'd2);
    end
    step(1'b1, mk(2'b01, 2'd0, 2'd0, 26'h50), 1'b1, "cc.t");
    check("cc.t.count", 32'(count), 32'd2);
    drain("cc.drain");

    // Route sweep at MY=(1,1).
    step(1'b1, mk(2'b11, 2'd1, 2'd2, 26'h60), 1'b1, "rt.n");
    check("rt.north", 32'(out_port), 32'd3);
    step(1'b1, mk(2'b01, 2'd0, 2'd0, 26'h61), 1'b1, "rt.nt");
    step(1'b1, mk(2'b11, 2'd1, 2'd0, 26'h62), 1'b1, "rt.s");
    check("rt.south", 32'(out_port), 32'd4);
    step(1'b1, mk(2'b01, 2'd0, 2'd0, 26'h63), 1'b1, "rt.st");
    step(1'b1, mk(2'b11, 2'd0, 2'd1, 26'h64), 1'b1, "rt.w");
    check("rt.west", 32'(out_port), 32'd2);
    step(1'b1, mk(2'b01, 2'd0, 2'd0, 26'h65), 1'b1, "rt.wt");
    step(1'b1, mk(2'b11, 2'd1, 2'd1, 26'h66), 1'b1, "rt.l");
    check("rt.local", 32'(out_port), 32'd0);
    step(1'b1, mk(2'b01, 2'd0, 2'd0, 26'h67), 1'b1, "rt.lt");
    drain("rt.drain");

    // Random traffic, including idle flits and framing violations.
    for (int i = 0; i < 500; i++) begin
      t = 2'($urandom_range(0, 3));
      f = mk(t, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 26'($urandom));
      step(1'($urandom_range(0, 9) < 7), f, 1'($urandom_range(0, 9) < 6), "rnd");
    end
    drain("rnd.drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
